// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// voice_allocator : four-voice MIDI note allocator with age-ordered stealing
// Revision        : 1.0
// ============================================================================
module voice_allocator #(
    parameter int STEAL_EN   = 1,
    parameter int NUM_VOICES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ev_valid_i,
    output logic        ev_ready_o,
    input  logic        ev_on_i,
    input  logic [6:0]  ev_note_i,
    input  logic [6:0]  ev_vel_i,
    input  logic        all_off_i,
    output logic [31:0] note_o,
    output logic [3:0]  active_o,
    output logic        stolen_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic                        live_q;
    logic                        ev_on_q;
    logic [6:0]                  ev_note_q;
    logic [6:0]                  ev_vel_q;
    logic                        match_vld_q, match_vld_d;
    logic [1:0]                  match_idx_q, match_idx_d;
    logic                        free_vld_q, free_vld_d;
    logic [1:0]                  free_idx_q, free_idx_d;
    logic [1:0]                  oldest_idx_q, oldest_idx_d;
    logic [NUM_VOICES-1:0][6:0]  note_q, note_d;
    logic [NUM_VOICES-1:0]       active_q, active_d;
    logic [NUM_VOICES-1:0][1:0]  age_q, age_d;

    logic                        best_vld;
    logic [1:0]                  best_age;
    logic                        on_eff;
    logic                        tgt_vld;
    logic                        bump_all;
    logic                        steal;
    logic [1:0]                  tgt;
    logic [1:0]                  old_age;

    // ready is held low until the first edge after reset release
    assign ev_ready_o = live_q & (state_q == S_IDLE) & ~all_off_i;
    assign active_o   = active_q;
    assign stolen_o   = steal & ~all_off_i;

    always_comb begin
        note_o = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_o[8*i +: 8] = active_q[i] ? {1'b0, note_q[i]} : 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ev_valid_i && ev_ready_o) state_d = S_SEARCH;
            S_SEARCH: state_d = S_COMMIT;
            default:  state_d = S_IDLE;
        endcase
        if (all_off_i) state_d = S_IDLE;
    end

    // Downward scans let the lowest index win; the oldest scan uses strict >
    always_comb begin
        match_vld_d  = 1'b0;
        match_idx_d  = 2'd0;
        free_vld_d   = 1'b0;
        free_idx_d   = 2'd0;
        best_vld     = 1'b0;
        best_age     = 2'd0;
        oldest_idx_d = 2'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active_q[i] && (note_q[i] == ev_note_q)) begin
                match_vld_d = 1'b1;
                match_idx_d = 2'(i);
            end
            if (!active_q[i]) begin
                free_vld_d = 1'b1;
                free_idx_d = 2'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && (!best_vld || (age_q[i] > best_age))) begin
                best_vld     = 1'b1;
                best_age     = age_q[i];
                oldest_idx_d = 2'(i);
            end
        end
    end

    always_comb begin
        note_d   = note_q;
        active_d = active_q;
        age_d    = age_q;
        on_eff   = ev_on_q & (|ev_vel_q);
        tgt_vld  = 1'b0;
        bump_all = 1'b0;
        steal    = 1'b0;
        tgt      = 2'd0;
        old_age  = 2'd0;
        if (state_q == S_COMMIT) begin
            if (on_eff) begin
                if (ev_note_q != 7'd0) begin
                    if (match_vld_q) begin
                        tgt_vld = 1'b1;
                        tgt     = match_idx_q;
                    end else if (free_vld_q) begin
                        tgt_vld  = 1'b1;
                        tgt      = free_idx_q;
                        bump_all = 1'b1;
                    end else if (STEAL_EN != 0) begin
                        tgt_vld = 1'b1;
                        tgt     = oldest_idx_q;
                        steal   = 1'b1;
                    end
                end
                if (tgt_vld) begin
                    old_age = age_q[tgt];
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if ((2'(i) != tgt) && active_q[i] && (bump_all || (age_q[i] < old_age))) begin
                            age_d[i] = age_q[i] + 2'd1;
                        end
                    end
                    note_d[tgt]   = ev_note_q;
                    active_d[tgt] = 1'b1;
                    age_d[tgt]    = 2'd0;
                end
            end else if (match_vld_q) begin
                old_age = age_q[match_idx_q];
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (active_q[i] && (age_q[i] > old_age)) begin
                        age_d[i] = age_q[i] - 2'd1;
                    end
                end
                note_d[match_idx_q]   = 7'd0;
                active_d[match_idx_q] = 1'b0;
                age_d[match_idx_q]    = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            live_q       <= 1'b0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= 7'd0;
            ev_vel_q     <= 7'd0;
            match_vld_q  <= 1'b0;
            match_idx_q  <= 2'd0;
            free_vld_q   <= 1'b0;
            free_idx_q   <= 2'd0;
            oldest_idx_q <= 2'd0;
            note_q       <= '0;
            active_q     <= '0;
            age_q        <= '0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            if (all_off_i) begin
                note_q   <= '0;
                active_q <= '0;
                age_q    <= '0;
            end else begin
                note_q   <= note_d;
                active_q <= active_d;
                age_q    <= age_d;
                if ((state_q == S_IDLE) && ev_valid_i && ev_ready_o) begin
                    ev_on_q   <= ev_on_i;
                    ev_note_q <= ev_note_i;
                    ev_vel_q  <= ev_vel_i;
                end
                if (state_q == S_SEARCH) begin
                    match_vld_q  <= match_vld_d;
                    match_idx_q  <= match_idx_d;
                    free_vld_q   <= free_vld_d;
                    free_idx_q   <= free_idx_d;
                    oldest_idx_q <= oldest_idx_d;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// tb_voice_allocator : directed bench for voice_allocator (steal and no-steal)
// Revision           : 1.0
// ============================================================================
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ev_valid = 1'b0;
    logic        ev_on = 1'b0;
    logic [6:0]  ev_note = 7'd0;
    logic [6:0]  ev_vel = 7'd0;
    logic        all_off = 1'b0;
    logic        rdy0, rdy1, st0, st1;
    logic [31:0] note0, note1;
    logic [3:0]  act0, act1;
    int          total = 0;
    int          bad = 0;
    int          sc0 = 0;
    int          sc1 = 0;

    always #5 clk = ~clk;

    voice_allocator #(.STEAL_EN(1), .NUM_VOICES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .ev_valid_i(ev_valid), .ev_ready_o(rdy0),
        .ev_on_i(ev_on), .ev_note_i(ev_note), .ev_vel_i(ev_vel), .all_off_i(all_off),
        .note_o(note0), .active_o(act0), .stolen_o(st0)
    );

    voice_allocator #(.STEAL_EN(0), .NUM_VOICES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .ev_valid_i(ev_valid), .ev_ready_o(rdy1),
        .ev_on_i(ev_on), .ev_note_i(ev_note), .ev_vel_i(ev_vel), .all_off_i(all_off),
        .note_o(note1), .active_o(act1), .stolen_o(st1)
    );

    always @(negedge clk) begin
        if (st0 === 1'b1) sc0++;
        if (st1 === 1'b1) sc1++;
    end

    task automatic do_reset();
        ev_valid = 1'b0;
        all_off  = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One event; returns #1 after the edge that ends COMMIT
    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (rdy0 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (rdy0 !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_ready_timeout note=%0d got ready=%b want 1", n, rdy0);
        end
        ev_valid = 1'b1; ev_on = on; ev_note = n; ev_vel = v;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b want 0", rdy0, rdy1); end
        total++; if (note0 !== 32'h0) begin bad++; $display("FAIL reset_note got=%h want 0", note0); end
        total++; if (act0 !== 4'b0000) begin bad++; $display("FAIL reset_active got=%b want 0000", act0); end
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL reset_stolen got=%b want 0", st0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want 0", rdy0); end
        @(posedge clk);
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL ready_first_edge got=%b want 1", rdy0); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL single_ready_pre got=%b want 1", rdy0); end
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(negedge clk);
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL single_ready_c1 got=%b want 0", rdy0); end
        @(negedge clk);
        total++; if (rdy0 !== 1'b0 || act0 !== 4'b0000) begin bad++; $display("FAIL single_c2 got ready=%b act=%b want 0/0000", rdy0, act0); end
        @(negedge clk);
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL single_ready_c3 got=%b want 1", rdy0); end
        total++; if (note0 !== 32'h0000003C || act0 !== 4'b0001) begin bad++; $display("FAIL single_note got=%h/%b want 0000003c/0001", note0, act0); end
    endtask

    task automatic test_steal();
        int b0, b1;
        do_reset();
        b0 = sc0; b1 = sc1;
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd62, 7'd100);
        send(1'b1, 7'd64, 7'd100);
        send(1'b1, 7'd65, 7'd100);
        total++; if (sc0 != b0) begin bad++; $display("FAIL steal_early got=%0d want 0", sc0 - b0); end
        send(1'b1, 7'd67, 7'd100);
        total++; if (note0 !== 32'h41403E43 || act0 !== 4'b1111) begin bad++; $display("FAIL steal_note got=%h/%b want 41403e43/1111", note0, act0); end
        total++; if (sc0 - b0 != 1) begin bad++; $display("FAIL steal_pulses got=%0d want 1", sc0 - b0); end
        total++; if (note1 !== 32'h41403E3C || act1 !== 4'b1111) begin bad++; $display("FAIL nosteal_note got=%h/%b want 41403e3c/1111", note1, act1); end
        total++; if (sc1 != b1) begin bad++; $display("FAIL nosteal_pulses got=%0d want 0", sc1 - b1); end
        send(1'b1, 7'd69, 7'd100);
        total++; if (note0 !== 32'h41404543) begin bad++; $display("FAIL steal2_note got=%h want 41404543", note0); end
        total++; if (sc0 - b0 != 2) begin bad++; $display("FAIL steal2_pulses got=%0d want 2", sc0 - b0); end
    endtask

    task automatic test_retrigger();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd62, 7'd100);
        send(1'b1, 7'd60, 7'd80);
        total++; if (note0 !== 32'h00003E3C || act0 !== 4'b0011) begin bad++; $display("FAIL retrig_note got=%h/%b want 00003e3c/0011", note0, act0); end
        send(1'b1, 7'd64, 7'd100);
        send(1'b1, 7'd65, 7'd100);
        send(1'b1, 7'd67, 7'd100);
        total++; if (note0 !== 32'h4140433C) begin bad++; $display("FAIL retrig_steal got=%h want 4140433c", note0); end
        total++; if (note1 !== 32'h41403E3C) begin bad++; $display("FAIL retrig_nosteal got=%h want 41403e3c", note1); end
    endtask

    task automatic test_note_off();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd60, 7'd0);
        total++; if (note0 !== 32'h0 || act0 !== 4'b0000) begin bad++; $display("FAIL vel0_off got=%h/%b want 0/0000", note0, act0); end
        send(1'b1, 7'd62, 7'd100);
        send(1'b0, 7'd61, 7'd64);
        total++; if (note0 !== 32'h0000003E || act0 !== 4'b0001) begin bad++; $display("FAIL off_nomatch got=%h/%b want 0000003e/0001", note0, act0); end
        send(1'b1, 7'd0, 7'd50);
        total++; if (note0 !== 32'h0000003E || act0 !== 4'b0001) begin bad++; $display("FAIL note_zero got=%h/%b want 0000003e/0001", note0, act0); end
        send(1'b1, 7'd64, 7'd100);
        send(1'b0, 7'd64, 7'd0);
        total++; if (note0 !== 32'h0000003E || act0 !== 4'b0001) begin bad++; $display("FAIL off_match got=%h/%b want 0000003e/0001", note0, act0); end
        send(1'b1, 7'd66, 7'd100);
        send(1'b1, 7'd67, 7'd100);
        send(1'b1, 7'd68, 7'd100);
        send(1'b1, 7'd70, 7'd100);
        total++; if (note0 !== 32'h44434246) begin bad++; $display("FAIL age_decrement got=%h want 44434246", note0); end
    endtask

    task automatic test_all_off();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd62, 7'd100);
        send(1'b1, 7'd64, 7'd100);
        total++; if (act0 !== 4'b0111) begin bad++; $display("FAIL alloff_setup got=%b want 0111", act0); end
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd65; ev_vel = 7'd90;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(negedge clk);
        all_off = 1'b1;
        @(posedge clk);
        #1;
        total++; if (note0 !== 32'h0 || act0 !== 4'b0000) begin bad++; $display("FAIL alloff_clear got=%h/%b want 0/0000", note0, act0); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL alloff_ready got=%b want 0", rdy0); end
        @(negedge clk);
        all_off = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (note0 !== 32'h0 || act0 !== 4'b0000 || rdy0 !== 1'b1) begin bad++; $display("FAIL alloff_discard got=%h/%b/%b want 0/0000/1", note0, act0, rdy0); end
        @(negedge clk);
        all_off = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_vel = 7'd50;
        @(posedge clk);
        @(negedge clk);
        all_off = 1'b0; ev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (act0 !== 4'b0000) begin bad++; $display("FAIL alloff_noaccept got=%b want 0000", act0); end
    endtask

    task automatic test_reset_commit();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd62; ev_vel = 7'd100;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (note0 !== 32'h0 || act0 !== 4'b0000 || rdy0 !== 1'b0 || st0 !== 1'b0) begin
            bad++; $display("FAIL rst_commit got=%h/%b/%b/%b want 0/0000/0/0", note0, act0, rdy0, st0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b want 0", rdy0); end
        @(posedge clk);
        #1;
        total++; if (rdy0 !== 1'b1 || act0 !== 4'b0000) begin bad++; $display("FAIL rst_return got=%b/%b want 1/0000", rdy0, act0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_steal();
        test_retrigger();
        test_note_off();
        test_all_off();
        test_reset_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
